// File: rtl/chopper_array_if.sv
// chopper_array_if: control/status bundle between the chopper and its DAC/comparator and bridge logic
interface chopper_array_if #(
  parameter int CHANNELS = 2,
  parameter int OFF_W = 10,
  parameter int BLANK_W = 8
);
  logic [CHANNELS-1:0] enable;
  logic [CHANNELS-1:0] cmp;
  logic [OFF_W-1:0] config_offtime;
  logic [OFF_W-1:0] config_fastdecay_threshold;
  logic [BLANK_W-1:0] config_blanktime;
  logic [BLANK_W-1:0] config_minimum_on_time;
  logic [CHANNELS-1:0] drive;
  logic [CHANNELS-1:0] fast_decay;
  logic [CHANNELS-1:0] slow_decay;
  logic [CHANNELS-1:0] chop_tick;
  logic [CHANNELS-1:0] fault;
  logic faultn;
  modport slave (
    input enable, cmp, config_offtime, config_fastdecay_threshold, config_blanktime, config_minimum_on_time,
    output drive, fast_decay, slow_decay, chop_tick, fault, faultn
  );
  modport master (
    output enable, cmp, config_offtime, config_fastdecay_threshold, config_blanktime, config_minimum_on_time,
    input drive, fast_decay, slow_decay, chop_tick, fault, faultn
  );
endinterface

// File: rtl/chopper_array.sv
// chopper_array: N-channel fixed-off-time current chopper with consecutive-immediate-trip fault latch
module chopper_array #(
  parameter int CHANNELS = 2,
  parameter int OFF_W = 10,
  parameter int BLANK_W = 8,
  parameter int FAULT_LIMIT = 4
) (
  input logic clk,
  input logic resetn,
  chopper_array_if.slave bus
);
  localparam int CW = OFF_W > BLANK_W ? OFF_W : BLANK_W;
  localparam int TW = $clog2(FAULT_LIMIT + 1);
  typedef enum logic [2:0] {IDLE, BLANK, ON, OFF, FAULT} state_t;
  logic [CHANNELS-1:0] fault_nxt;
  logic no_fault;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t st;
    logic [CW-1:0] cnt;
    logic [BLANK_W-1:0] mcnt, m_dec;
    logic [OFF_W-1:0] fcnt, f_dec;
    logic [TW-1:0] trips;
    logic seen, drv, fast, slow, tick, flt;
    logic en, cnt_done, m_exp, trip, imm, to_fault;
    assign en = bus.enable[i];
    // A counter loaded with V finishes when it holds 0 or 1, so V=0 behaves as 1.
    assign cnt_done = cnt[CW-1:1] == '0;
    assign m_exp = mcnt[BLANK_W-1:1] == '0;
    assign m_dec = mcnt == '0 ? mcnt : mcnt - BLANK_W'(1);
    assign f_dec = fcnt == '0 ? fcnt : fcnt - OFF_W'(1);
    assign trip = st == ON && bus.cmp[i] && m_exp;
    // Immediate trip: no earlier eligible ON cycle went by with the comparator low.
    assign imm = trip && !seen;
    assign to_fault = imm && trips == TW'(FAULT_LIMIT - 1);
    assign fault_nxt[i] = en && (flt || to_fault);
    assign bus.drive[i] = drv;
    assign bus.fast_decay[i] = fast;
    assign bus.slow_decay[i] = slow;
    assign bus.chop_tick[i] = tick;
    assign bus.fault[i] = flt;
    // Per-channel FSM; outputs are registered together with the state they describe.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        st <= IDLE;
        cnt <= '0;
        mcnt <= '0;
        fcnt <= '0;
        trips <= '0;
        seen <= 1'b0;
        drv <= 1'b0;
        fast <= 1'b0;
        slow <= 1'b0;
        tick <= 1'b0;
        flt <= 1'b0;
      end else if (!en) begin
        st <= IDLE;
        trips <= '0;
        drv <= 1'b0;
        fast <= 1'b0;
        slow <= 1'b0;
        tick <= 1'b0;
        flt <= 1'b0;
      end else begin
        tick <= 1'b0;
        flt <= fault_nxt[i];
        case (st)
          IDLE: begin
            st <= BLANK;
            cnt <= CW'(bus.config_blanktime);
            mcnt <= bus.config_minimum_on_time;
            seen <= 1'b0;
            drv <= 1'b1;
          end
          BLANK: begin
            mcnt <= m_dec;
            if (cnt_done) st <= ON;
            else cnt <= cnt - CW'(1);
          end
          ON: begin
            if (to_fault) begin
              st <= FAULT;
              drv <= 1'b0;
            end else if (trip) begin
              st <= OFF;
              cnt <= CW'(bus.config_offtime);
              fcnt <= bus.config_fastdecay_threshold;
              drv <= 1'b0;
              tick <= 1'b1;
              fast <= bus.config_fastdecay_threshold != '0;
              slow <= bus.config_fastdecay_threshold == '0;
              trips <= imm ? trips + TW'(1) : '0;
            end else begin
              mcnt <= m_dec;
              seen <= seen | m_exp;
            end
          end
          OFF: begin
            if (cnt_done) begin
              st <= BLANK;
              cnt <= CW'(bus.config_blanktime);
              mcnt <= bus.config_minimum_on_time;
              seen <= 1'b0;
              drv <= 1'b1;
              fast <= 1'b0;
              slow <= 1'b0;
            end else begin
              cnt <= cnt - CW'(1);
              fcnt <= f_dec;
              fast <= f_dec != '0;
              slow <= f_dec == '0;
            end
          end
          default: ;
        endcase
      end
    end
  end
  // Summary fault flag tracks the same next-state fault bits the channels latch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) no_fault <= 1'b1;
    else no_fault <= ~|fault_nxt;
  end
  assign bus.faultn = no_fault;
endmodule

// File: tb/tb_chopper_array.sv
// tb_chopper_array: directed checks of the chopper FSM, decay split, fault latch and resets
module tb_chopper_array;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [3:0] o0;
  always #5 clk = ~clk;
  chopper_array_if #(.CHANNELS(3), .OFF_W(10), .BLANK_W(8)) bus();
  chopper_array #(.CHANNELS(3), .OFF_W(10), .BLANK_W(8), .FAULT_LIMIT(4)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus.slave)
  );
  assign o0 = {bus.drive[0], bus.fast_decay[0], bus.slow_decay[0], bus.chop_tick[0]};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [9:0] off, input logic [9:0] thr, input logic [7:0] bl, input logic [7:0] mo);
    bus.config_offtime = off;
    bus.config_fastdecay_threshold = thr;
    bus.config_blanktime = bl;
    bus.config_minimum_on_time = mo;
  endtask

  task automatic test_reset();
    bus.enable = '0;
    bus.cmp = '0;
    cfg(0, 0, 0, 0);
    resetn = 1'b0;
    step();
    step();
    tests++;
    if ({bus.drive, bus.fast_decay, bus.slow_decay, bus.chop_tick, bus.fault} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h want 0", {bus.drive, bus.fast_decay, bus.slow_decay, bus.chop_tick, bus.fault});
    end
    tests++;
    if (bus.faultn !== 1'b1) begin
      fails++;
      $display("FAIL reset_faultn: got %b want 1", bus.faultn);
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_chop();
    logic [3:0] exp;
    cfg(10, 4, 3, 5);
    bus.cmp = '0;
    bus.enable = 3'b001;
    for (int k = 1; k <= 19; k++) begin
      step();
      exp = k <= 8 ? 4'b1000 : k == 9 ? 4'b0101 : k <= 12 ? 4'b0100 : k <= 18 ? 4'b0010 : 4'b1000;
      tests++;
      if (o0 !== exp) begin
        fails++;
        $display("FAIL chop cycle %0d: got %b want %b", k, o0, exp);
      end
      if (k == 8) bus.cmp[0] = 1'b1;
      if (k == 9) bus.cmp[0] = 1'b0;
    end
    bus.enable = '0;
    step();
    tests++;
    if (o0 !== 4'b0000) begin
      fails++;
      $display("FAIL chop_disable: got %b want 0000", o0);
    end
  endtask

  task automatic test_fault();
    int ticks = 0;
    cfg(2, 1, 2, 2);
    bus.cmp = 3'b001;
    bus.enable = 3'b001;
    for (int k = 1; k <= 21; k++) begin
      step();
      ticks += int'(bus.chop_tick[0]);
      if (k == 18) begin
        tests++;
        if (bus.fault[0] !== 1'b0) begin
          fails++;
          $display("FAIL fault_early: got %b want 0", bus.fault[0]);
        end
      end
      if (k == 19 || k == 21) begin
        tests++;
        if ({bus.fault[0], bus.faultn, o0} !== 6'b100000) begin
          fails++;
          $display("FAIL fault_latched cycle %0d: got %b want 100000", k, {bus.fault[0], bus.faultn, o0});
        end
      end
    end
    tests++;
    if (ticks != 3) begin
      fails++;
      $display("FAIL fault_ticks: got %0d want 3", ticks);
    end
    bus.enable = '0;
    step();
    tests++;
    if ({bus.fault[0], bus.faultn} !== 2'b01) begin
      fails++;
      $display("FAIL fault_clear: got %b want 01", {bus.fault[0], bus.faultn});
    end
  endtask

  task automatic test_trip_reset();
    int ticks = 0;
    cfg(2, 1, 2, 2);
    bus.cmp = 3'b001;
    bus.enable = 3'b001;
    for (int k = 1; k <= 40; k++) begin
      step();
      ticks += int'(bus.chop_tick[0]);
      if (k == 18) bus.cmp[0] = 1'b0;
      if (k == 19) bus.cmp[0] = 1'b1;
      if (k == 39) begin
        tests++;
        if ({bus.fault[0], bus.faultn} !== 2'b01 || ticks != 7) begin
          fails++;
          $display("FAIL trip_reset_nofault: got fault %b ticks %0d want 0 and 7", bus.fault[0], ticks);
        end
      end
      if (k == 40) begin
        tests++;
        if (bus.fault[0] !== 1'b1) begin
          fails++;
          $display("FAIL trip_reset_fourth: got %b want 1", bus.fault[0]);
        end
      end
    end
    bus.enable = '0;
    step();
  endtask

  task automatic test_disable_mid();
    logic [3:0] exp;
    cfg(8, 3, 5, 1);
    bus.cmp = 3'b001;
    bus.enable = 3'b001;
    for (int k = 1; k <= 21; k++) begin
      step();
      exp = k <= 6 ? 4'b1000 : k == 7 ? 4'b0101 : k <= 9 ? 4'b0100 : k == 10 ? 4'b0000 :
            k <= 13 ? 4'b1000 : k == 14 ? 4'b0000 : k <= 20 ? 4'b1000 : 4'b0101;
      tests++;
      if (o0 !== exp) begin
        fails++;
        $display("FAIL disable_mid cycle %0d: got %b want %b", k, o0, exp);
      end
      if (k == 9 || k == 13) bus.enable[0] = 1'b0;
      if (k == 10 || k == 14) bus.enable[0] = 1'b1;
    end
    bus.enable = '0;
    step();
  endtask

  task automatic test_zero_config();
    logic [3:0] exp;
    cfg(0, 0, 0, 0);
    bus.cmp = 3'b001;
    bus.enable = 3'b001;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = k == 12 ? 4'b0000 : k % 3 == 0 ? 4'b0011 : 4'b1000;
      tests++;
      if (o0 !== exp) begin
        fails++;
        $display("FAIL zero_cfg cycle %0d: got %b want %b", k, o0, exp);
      end
    end
    tests++;
    if (bus.fault[0] !== 1'b1) begin
      fails++;
      $display("FAIL zero_cfg_fault: got %b want 1", bus.fault[0]);
    end
    bus.enable = '0;
    step();
  endtask

  task automatic test_multi_channel();
    cfg(2, 1, 2, 2);
    bus.cmp = 3'b111;
    bus.enable = 3'b111;
    for (int k = 1; k <= 21; k++) begin
      step();
      if (k == 5 || k == 11 || k == 17) begin
        tests++;
        if (bus.chop_tick !== 3'b101) begin
          fails++;
          $display("FAIL multi_tick cycle %0d: got %b want 101", k, bus.chop_tick);
        end
      end
      if (k == 19) begin
        tests++;
        if ({bus.fault, bus.faultn, bus.drive} !== 7'b0100101) begin
          fails++;
          $display("FAIL multi_fault: got %b want 0100101", {bus.fault, bus.faultn, bus.drive});
        end
      end
      if (k == 21) begin
        tests++;
        if (bus.drive !== 3'b101) begin
          fails++;
          $display("FAIL multi_on: got %b want 101", bus.drive);
        end
      end
      bus.cmp[0] = k % 6 != 3;
      bus.cmp[2] = k % 6 != 3;
    end
    resetn = 1'b0;
    #1;
    tests++;
    if ({bus.drive, bus.fast_decay, bus.slow_decay, bus.chop_tick, bus.fault, bus.faultn} !== 16'h0001) begin
      fails++;
      $display("FAIL async_reset: got %h want 0001", {bus.drive, bus.fast_decay, bus.slow_decay, bus.chop_tick, bus.fault, bus.faultn});
    end
    #2;
    resetn = 1'b1;
    step();
    tests++;
    if ({bus.chop_tick, bus.drive, bus.fault} !== 9'b000111000) begin
      fails++;
      $display("FAIL post_reset: got %b want 000111000", {bus.chop_tick, bus.drive, bus.fault});
    end
  endtask

  initial begin
    test_reset();
    test_chop();
    test_fault();
    test_trip_reset();
    test_disable_mid();
    test_zero_config();
    test_multi_channel();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
